// File: rtl/gate_pkg.sv
// Shared types and constants for the fare-gate paddle-door controller.
package gate_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN_WAIT,
        ST_PASSING,
        ST_CLOSING,
        ST_FAULT,
        ST_MAINT
    } door_state_t;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_OPEN_TO    = 2'd1,
        FC_CLOSE_TO   = 2'd2
    } door_fault_t;

    localparam int PEND_MAX = 7;
    localparam int PEND_W   = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/deduct_queue.sv
// Pending-deduction counter with req/ack handshake towards the account back-end.
module deduct_queue
    import gate_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic reduce_bal,
    input  logic deduct_ack,
    output logic deduct_req
);

    logic [PEND_W-1:0] pending;
    logic              inc;
    logic              dec;

    // An ack with nothing pending is dropped rather than underflowing.
    assign inc        = reduce_bal;
    assign dec        = deduct_ack && (pending != '0);
    assign deduct_req = (pending != '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (inc && !dec) begin
            if (pending != PEND_W'(PEND_MAX))
                pending <= pending + PEND_W'(1);
        end else if (dec && !inc) begin
            pending <= pending - PEND_W'(1);
        end
    end

endmodule

// File: rtl/gate_door_ctrl.sv
// Paddle-door motor sequencer: open, pass, close, anti-pinch reopen, motor timeout fault,
// passenger count, and forwarding of fare deductions.
module gate_door_ctrl
    import gate_pkg::*;
#(
    parameter int MOTOR_TICKS = 200,
    parameter int HOLD_TICKS  = 500,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             open,
    input  logic             reduce_bal,
    input  logic             maintenance,
    input  logic             door_open_lim,
    input  logic             door_closed_lim,
    input  logic             pass_sensor,
    input  logic             deduct_ack,
    output logic             motor_open,
    output logic             motor_close,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic             deduct_req,
    output logic [CNT_W-1:0] pax_count
);

    localparam int TIMER_W = $clog2(max_int(MOTOR_TICKS, HOLD_TICKS) + 1);
    localparam logic [TIMER_W-1:0] MOTOR_LAST = TIMER_W'(MOTOR_TICKS - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(HOLD_TICKS - 1);

    door_state_t        state;
    door_state_t        state_nx;
    door_fault_t        fault_q;
    door_fault_t        fault_nx;
    logic [TIMER_W-1:0] timer;
    logic               open_q;
    logic               open_edge;
    logic               pax_inc;

    assign open_edge  = open && !open_q;
    assign fault_code = fault_q;

    // NOTE: every variable gets a default first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        fault_nx = fault_q;
        pax_inc  = 1'b0;
        case (state)
            ST_CLOSED: begin
                if (maintenance)
                    state_nx = ST_MAINT;
                else if (open_edge)
                    state_nx = ST_OPENING;
            end
            ST_OPENING: begin
                if (door_open_lim) begin
                    state_nx = ST_OPEN_WAIT;
                end else if (timer == MOTOR_LAST) begin
                    state_nx = ST_FAULT;
                    fault_nx = FC_OPEN_TO;
                end
            end
            ST_OPEN_WAIT: begin
                if (pass_sensor)
                    state_nx = ST_PASSING;
                else if (timer == HOLD_LAST)
                    state_nx = ST_CLOSING;
            end
            ST_PASSING: begin
                if (!pass_sensor) begin
                    state_nx = ST_CLOSING;
                    pax_inc  = 1'b1;
                end
            end
            ST_CLOSING: begin
                // Anyone in the beam, or a fresh open request, wins over the closed limit.
                if (pass_sensor || open_edge) begin
                    state_nx = ST_OPENING;
                end else if (door_closed_lim) begin
                    state_nx = ST_CLOSED;
                end else if (timer == MOTOR_LAST) begin
                    state_nx = ST_FAULT;
                    fault_nx = FC_CLOSE_TO;
                end
            end
            ST_FAULT: begin
                if (maintenance) begin
                    state_nx = ST_MAINT;
                    fault_nx = FC_NONE;
                end
            end
            ST_MAINT: begin
                if (!maintenance)
                    state_nx = door_closed_lim ? ST_CLOSED : ST_CLOSING;
            end
            default: begin
                state_nx = ST_CLOSED;
                fault_nx = FC_NONE;
            end
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly,
    // and the asynchronous reset drops the motors without waiting for an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_CLOSED;
            fault_q     <= FC_NONE;
            timer       <= '0;
            open_q      <= 1'b0;
            pax_count   <= '0;
            motor_open  <= 1'b0;
            motor_close <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state   <= state_nx;
            fault_q <= fault_nx;
            open_q  <= open;
            if (state_nx != state)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + TIMER_W'(1);
            if (pax_inc)
                pax_count <= pax_count + CNT_W'(1);
            motor_open  <= (state_nx == ST_OPENING);
            motor_close <= (state_nx == ST_CLOSING);
            busy        <= !(state_nx inside {ST_CLOSED, ST_MAINT, ST_FAULT});
            fault       <= (state_nx == ST_FAULT);
        end
    end

    deduct_queue u_deduct_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .reduce_bal (reduce_bal),
        .deduct_ack (deduct_ack),
        .deduct_req (deduct_req)
    );

endmodule

// File: tb/tb_gate_door_ctrl.sv
// Directed bench for gate_door_ctrl: vector table for the main flow plus hand-written corner sequences.
module tb_gate_door_ctrl;

    localparam int MOTOR = 12;
    localparam int HOLD  = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          open, reduce_bal, maintenance, door_open_lim, door_closed_lim, pass_sensor, deduct_ack;
    logic          motor_open, motor_close, busy, fault, deduct_req;
    logic [1:0]    fault_code;
    logic [CW-1:0] pax_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gate_door_ctrl #(.MOTOR_TICKS(MOTOR), .HOLD_TICKS(HOLD), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .open            (open),
        .reduce_bal      (reduce_bal),
        .maintenance     (maintenance),
        .door_open_lim   (door_open_lim),
        .door_closed_lim (door_closed_lim),
        .pass_sensor     (pass_sensor),
        .deduct_ack      (deduct_ack),
        .motor_open      (motor_open),
        .motor_close     (motor_close),
        .busy            (busy),
        .fault           (fault),
        .fault_code      (fault_code),
        .deduct_req      (deduct_req),
        .pax_count       (pax_count)
    );

    typedef struct {
        string      name;
        logic       open, rb, maint, olim, clim, pass, ack;
        int         n;
        logic       mo, mc, busy, flt;
        logic [1:0] fc;
        logic       req;
        logic [CW-1:0] pax;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Packed order: motor_open, motor_close, busy, fault, fault_code[1:0], deduct_req.
    task automatic chk_out(input string name, input logic mo, input logic mc, input logic bz,
                           input logic fl, input logic [1:0] fc, input logic rq);
        check(name, {motor_open, motor_close, busy, fault, fault_code, deduct_req},
                    {mo, mc, bz, fl, fc, rq});
    endtask

    task automatic set_in(input logic op, input logic rb, input logic mt, input logic ol,
                          input logic cl, input logic ps, input logic ak);
        open = op; reduce_bal = rb; maintenance = mt; door_open_lim = ol;
        door_closed_lim = cl; pass_sensor = ps; deduct_ack = ak;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        //                name          op rb mt ol cl ps ak  n  mo mc bz fl fc req pax
        vecs[0]  = '{"reset_idle",   0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{"open_rise",    1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{"opening",      1, 0, 0, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0, 0};
        vecs[3]  = '{"open_lim",     1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[4]  = '{"hold_open",    0, 0, 0, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0, 0};
        vecs[5]  = '{"pass_on",      0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0};
        vecs[6]  = '{"passing",      0, 0, 0, 1, 0, 1, 0, 4, 0, 0, 1, 0, 0, 0, 0};
        vecs[7]  = '{"pass_off",     0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1};
        vecs[8]  = '{"closing",      0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 1, 0, 0, 0, 1};
        vecs[9]  = '{"closed_lim",   0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[10] = '{"rb_1",         0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[11] = '{"rb_2",         0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[12] = '{"rb_3",         0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[13] = '{"rb_and_ack",   0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[14] = '{"ack_1",        0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[15] = '{"ack_2",        0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1};
        vecs[16] = '{"ack_3",        0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
        vecs[17] = '{"ack_empty",    0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        step(2);
        chk_out("in_reset", 0, 0, 0, 0, 2'd0, 0);
        check("in_reset_pax", 32'(pax_count), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            set_in(vecs[i].open, vecs[i].rb, vecs[i].maint, vecs[i].olim,
                   vecs[i].clim, vecs[i].pass, vecs[i].ack);
            step(vecs[i].n);
            chk_out(vecs[i].name, vecs[i].mo, vecs[i].mc, vecs[i].busy, vecs[i].flt,
                    vecs[i].fc, vecs[i].req);
            check({vecs[i].name, "_pax"}, 32'(pax_count), 32'(vecs[i].pax));
        end

        // No passenger: door closes exactly HOLD cycles after OPEN_WAIT is entered.
        set_in(1, 0, 0, 0, 0, 0, 0); step(1);
        chk_out("np_opening", 1, 0, 1, 0, 2'd0, 0);
        set_in(1, 0, 0, 1, 0, 0, 0); step(1);
        chk_out("np_open_wait", 0, 0, 1, 0, 2'd0, 0);
        step(HOLD - 1);
        chk_out("np_still_wait", 0, 0, 1, 0, 2'd0, 0);
        step(1);
        chk_out("np_closing", 0, 1, 1, 0, 2'd0, 0);
        check("np_pax", 32'(pax_count), 1);

        // Anti-pinch: beam broken while closing reopens on the very next edge.
        set_in(0, 0, 0, 0, 0, 1, 0); step(1);
        chk_out("pinch_reopen", 1, 0, 1, 0, 2'd0, 0);
        set_in(0, 0, 0, 1, 0, 0, 0); step(1);
        chk_out("pinch_open_wait", 0, 0, 1, 0, 2'd0, 0);

        // Close timeout, then maintenance recovery.
        step(HOLD);
        chk_out("to_closing", 0, 1, 1, 0, 2'd0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(MOTOR - 1);
        chk_out("to_still_closing", 0, 1, 1, 0, 2'd0, 0);
        step(1);
        chk_out("to_fault", 0, 0, 0, 1, 2'd2, 0);
        step(3);
        chk_out("to_fault_hold", 0, 0, 0, 1, 2'd2, 0);
        set_in(0, 0, 1, 0, 0, 0, 0); step(1);
        chk_out("to_maint", 0, 0, 0, 0, 2'd0, 0);
        set_in(1, 0, 1, 0, 0, 0, 0); step(2);
        chk_out("to_maint_open_ignored", 0, 0, 0, 0, 2'd0, 0);
        set_in(1, 0, 0, 0, 1, 0, 0); step(2);
        chk_out("to_closed", 0, 0, 0, 0, 2'd0, 0);

        // Maintenance has priority over an open edge in CLOSED.
        set_in(0, 0, 0, 0, 1, 0, 0); step(1);
        set_in(1, 0, 1, 0, 1, 0, 0); step(1);
        chk_out("mt_no_motion", 0, 0, 0, 0, 2'd0, 0);
        step(3);
        chk_out("mt_still_idle", 0, 0, 0, 0, 2'd0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0); step(1);
        chk_out("mt_exit_closing", 0, 1, 1, 0, 2'd0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0); step(1);
        chk_out("mt_closed", 0, 0, 0, 0, 2'd0, 0);

        // Open timeout reports code 1; leaving MAINT with the door ajar goes to CLOSING.
        set_in(1, 0, 0, 0, 0, 0, 0); step(1);
        chk_out("ot_opening", 1, 0, 1, 0, 2'd0, 0);
        step(MOTOR - 1);
        chk_out("ot_still_opening", 1, 0, 1, 0, 2'd0, 0);
        step(1);
        chk_out("ot_fault", 0, 0, 0, 1, 2'd1, 0);
        set_in(0, 0, 1, 0, 0, 0, 0); step(1);
        chk_out("ot_maint", 0, 0, 0, 0, 2'd0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); step(1);
        chk_out("ot_closing", 0, 1, 1, 0, 2'd0, 0);
        set_in(0, 0, 0, 0, 1, 0, 0); step(1);
        chk_out("ot_closed", 0, 0, 0, 0, 2'd0, 0);

        // Nine pulses saturate the queue at 7: request drops only after the seventh ack.
        for (int i = 0; i < 9; i++) begin
            set_in(0, 1, 0, 0, 1, 0, 0); step(1);
        end
        for (int i = 0; i < 7; i++) begin
            set_in(0, 0, 0, 0, 1, 0, 1); step(1);
            check($sformatf("sat_ack_%0d", i + 1), 32'(deduct_req), (i < 6) ? 1 : 0);
        end

        // Asynchronous reset in the middle of an opening stroke.
        set_in(1, 0, 0, 0, 0, 0, 0); step(1);
        chk_out("rst_opening", 1, 0, 1, 0, 2'd0, 0);
        #2 rst_n = 1'b0;
        #1 chk_out("rst_async", 0, 0, 0, 0, 2'd0, 0);
        check("rst_pax", 32'(pax_count), 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        step(2);
        chk_out("rst_closed", 0, 0, 0, 0, 2'd0, 0);
        set_in(1, 0, 0, 0, 0, 0, 0); step(1);
        chk_out("rst_reopen", 1, 0, 1, 0, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_door_ctrl.md
# gate_door_ctrl

Downstream stage of the fare-gate `fsm`: consumes its `open`, `reduce_bal` and `maintenance` signals and drives the physical paddle-door motor. It sequences open, passenger-pass and close, including the anti-pinch reopen and motor-timeout fault. It counts passengers through the gate and forwards each balance deduction to the account back-end over a req/ack handshake.

## Interface
- `MOTOR_TICKS`, 200: maximum cycles the motor may run in one direction before a fault.
- `HOLD_TICKS`, 500: cycles the door stays open waiting for a passenger.
- `CNT_W`, 16: width of the passenger counter.
- `clk` in 1: single system clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `open` in 1: open request from the fare FSM; the rising edge is the event.
- `reduce_bal` in 1: one-cycle pulse requesting a fare deduction.
- `maintenance` in 1: maintenance mode level.
- `door_open_lim` in 1: limit switch, door fully open.
- `door_closed_lim` in 1: limit switch, door fully closed.
- `pass_sensor` in 1: beam broken (passenger in the gate).
- `deduct_ack` in 1: back-end acknowledges one deduction.
- `motor_open` out 1: drive motor in the open direction.
- `motor_close` out 1: drive motor in the close direction.
- `busy` out 1: state is not CLOSED, MAINT or FAULT.
- `fault` out 1: state is FAULT.
- `fault_code` out 2: 0 none, 1 open timeout, 2 close timeout.
- `deduct_req` out 1: a deduction is pending.
- `pax_count` out CNT_W: passengers passed. Wraps at 2^CNT_W.

## Operation
- States: CLOSED, OPENING, OPEN_WAIT, PASSING, CLOSING, FAULT, MAINT.
- `open_edge` = `open & ~open_q`. `open_q` is a register.
- CLOSED:
  - `maintenance` -> MAINT. This has priority.
  - else `open_edge` -> OPENING.
- OPENING:
  - `door_open_lim` -> OPEN_WAIT.
  - timer == MOTOR_TICKS-1 -> FAULT with code 1.
- OPEN_WAIT:
  - `pass_sensor` -> PASSING.
  - timer == HOLD_TICKS-1 -> CLOSING. No count.
- PASSING:
  - `!pass_sensor` -> CLOSING, and `pax_count` increments on that transition.
  - No timeout in this state.
- CLOSING:
  - `pass_sensor` or `open_edge` -> OPENING. This is the anti-pinch/reopen path and has priority.
  - else `door_closed_lim` -> CLOSED.
  - else timer == MOTOR_TICKS-1 -> FAULT with code 2.
- FAULT:
  - Motors off.
  - Stays until `maintenance`, then -> MAINT.
  - `fault_code` holds until FAULT is exited, then clears.
- MAINT:
  - Motors off.
  - On `!maintenance`: `door_closed_lim` -> CLOSED, else -> CLOSING.
- `open_edge` is ignored in OPENING, OPEN_WAIT and PASSING.
- `maintenance` is ignored in OPENING, OPEN_WAIT, PASSING and CLOSING. The current cycle completes first.
- Timer: a single up-counter that clears on every state change and saturates.
- Deduction queue:
  - A 3-bit pending count.
  - `reduce_bal` alone: +1, saturating at 7.
  - `deduct_ack` while `deduct_req`: -1.
  - Both in the same cycle: count unchanged.
  - `deduct_ack` when count is 0: ignored.
  - `deduct_req` = (count != 0).
  - The queue operates in every state, including FAULT and MAINT.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state CLOSED, timer 0, `open_q` 0, pending 0, `pax_count` 0.
  - Every output is 0.
- Reset mid-motion drops both motor outputs immediately, without waiting for a clock edge.
- State outputs (`motor_*`, `busy`, `fault`) are Moore outputs decoded from the state register.
  - `open` first sampled high at edge k -> `motor_open` high after edge k.
- `pax_count` updates at the edge that leaves PASSING.
- `deduct_req` rises after the edge that samples `reduce_bal`.
- `deduct_req` falls after the edge that samples the final `deduct_ack`.
- `motor_open` and `motor_close` are never high together.

## Structure
- Package `gate_pkg` contains:
  - the state enum `door_state_t`;
  - the fault-code enum `door_fault_t`;
  - localparam `PEND_MAX` = 7.
- Timer width is `$clog2(max(MOTOR_TICKS,HOLD_TICKS)+1)`.
- Sub-module `deduct_queue` holds the pending counter and the req/ack handshake. The door FSM remains in the top module.

## Test plan
- Happy path:
  - Stimulus: `open` rises; `door_open_lim` asserts after 10 cycles; `pass_sensor` pulses for 5 cycles; `door_closed_lim` asserts after 10 cycles.
  - Required: states OPENING -> OPEN_WAIT -> PASSING -> CLOSING -> CLOSED; `pax_count` 0 -> 1.
- No passenger:
  - Stimulus: HOLD_TICKS = 8; door opens; sensor stays quiet.
  - Required: CLOSING exactly 8 cycles after OPEN_WAIT is entered; `pax_count` stays 0.
- Anti-pinch:
  - Stimulus: `pass_sensor` goes high during CLOSING.
  - Required: next state OPENING; `motor_close` 0 and `motor_open` 1 after the same edge.
- Close timeout:
  - Stimulus: MOTOR_TICKS = 4; `door_closed_lim` never asserts.
  - Required: FAULT with `fault_code` = 2 after 4 CLOSING cycles.
  - Then assert `maintenance` -> MAINT.
  - Then release `maintenance` with `door_closed_lim` high -> CLOSED, `fault_code` = 0.
- Deduction queue:
  - Stimulus: 3 `reduce_bal` pulses with no ack; then `reduce_bal` and `deduct_ack` in the same cycle; then 3 acks.
  - Required: count 3 after the pulses; count 3 after the simultaneous cycle; count 0 after the acks, with `deduct_req` low.
  - Also: 9 pulses with no ack saturate the count at 7.
- Maintenance and reset:
  - Stimulus: `maintenance` in CLOSED, then `open` rises.
  - Required: no motion.
  - Stimulus: `rst_n` low during OPENING.
  - Required: `motor_open` 0 asynchronously; state CLOSED after release.
